// File: rtl/rendering_arith_pkg.sv
// rtl/rendering_arith_pkg.sv - shared arithmetic constants, width and saturation-bound helpers
package rendering_arith_pkg;

  localparam int MUL_MAX_STAGE = 6;

  // Operand signedness travels with each beat as this pair.
  typedef struct packed {
    logic sgn0;
    logic sgn1;
  } mul_mode_t;

  // Narrowest signed width that holds any product of the two extended operands in every mode.
  function automatic int mul_min_width(input int w0, input int w1);
    return w0 + w1 + 1;
  endfunction

  function automatic logic signed [63:0] sat_smax(input int n);
    return (64'sd1 <<< (n - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_smin(input int n);
    return -(64'sd1 <<< (n - 1));
  endfunction

  function automatic logic signed [63:0] sat_umax(input int n);
    return (64'sd1 <<< n) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_umin(input int n);
    return (n < 0) ? 64'sd1 : 64'sd0;
  endfunction

endpackage

// File: rtl/rendering_mul_narrow.sv
// rtl/rendering_mul_narrow.sv - combinational product narrowing with wrap or saturate and overflow flag
module rendering_mul_narrow
  import rendering_arith_pkg::*;
#(
  parameter int A_WIDTH = 14,
  parameter int B_WIDTH = 12,
  parameter int DW      = 26,
  parameter int SAT     = 0
) (
  input  logic signed [A_WIDTH+B_WIDTH+1:0] p,
  input  mul_mode_t                         mode,
  output logic        [DW-1:0]              dout,
  output logic                              ovf
);

  localparam int PW   = A_WIDTH + B_WIDTH + 2;
  localparam int MINW = mul_min_width(A_WIDTH, B_WIDTH);

  if (DW >= MINW) begin : g_exact
    assign dout = DW'(p);
    assign ovf  = 1'b0;
  end else begin : g_narrow
    logic signed [63:0] pl;
    logic signed [63:0] lo;
    logic signed [63:0] hi;
    logic               is_sgn;
    logic               below;
    logic               above;

    assign pl     = {{(64-PW){p[PW-1]}}, p};
    assign is_sgn = mode.sgn0 | mode.sgn1;
    assign lo     = is_sgn ? sat_smin(DW) : sat_umin(DW);
    assign hi     = is_sgn ? sat_smax(DW) : sat_umax(DW);
    assign below  = pl < lo;
    assign above  = pl > hi;
    assign ovf    = below | above;

    if (SAT != 0) begin : g_sat
      always_comb begin
        dout = pl[DW-1:0];
        if (below) dout = lo[DW-1:0];
        else if (above) dout = hi[DW-1:0];
      end
    end else begin : g_wrap
      assign dout = pl[DW-1:0];
    end
  end

endmodule

// File: rtl/rendering_mul_pipe.sv
// rtl/rendering_mul_pipe.sv - pipelined multiplier with per-beat signedness, full-pipe stall and narrowing
module rendering_mul_pipe
  import rendering_arith_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26,
  parameter int SAT        = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  sgn0,
  input  logic                  sgn1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_ovf
);

  localparam int AW = din0_WIDTH + 1;
  localparam int BW = din1_WIDTH + 1;
  localparam int PW = AW + BW;

  logic                  stall;
  logic                  advance;
  logic                  accept;
  logic [NUM_STAGE-1:0]  vld_q;
  logic [NUM_STAGE-1:0]  vld_next;
  mul_mode_t             in_mode;
  logic signed [AW-1:0]  a_ext;
  logic signed [BW-1:0]  b_ext;
  mul_mode_t             m_q [NUM_STAGE];
  logic [PW-1:0]         d_q [NUM_STAGE];
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  narrow_p;
  mul_mode_t             narrow_m;
  logic [dout_WIDTH-1:0] narrow_dout;
  logic                  narrow_ovf;
  logic [dout_WIDTH-1:0] dout_q;
  logic                  ovf_q;

  assign in_mode = {sgn0, sgn1};
  assign a_ext   = {sgn0 & din0[din0_WIDTH-1], din0};
  assign b_ext   = {sgn1 & din1[din1_WIDTH-1], din1};

  // Any unconsumed result freezes the whole pipe, so bubbles keep their place.
  assign stall    = vld_q[NUM_STAGE-1] & ~out_ready;
  assign advance  = ce & ~stall;
  assign in_ready = ~stall & ce & ap_rst_n;
  assign accept   = in_valid & in_ready;
  assign vld_next = (vld_q << 1) | NUM_STAGE'(accept);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      vld_q <= '0;
    end else if (advance) begin
      vld_q <= vld_next;
    end
  end

  if (NUM_STAGE >= 2) begin : g_prod
    assign prod = PW'($signed(d_q[0][PW-1:BW])) * PW'($signed(d_q[0][BW-1:0]));
  end

  // Stage 0 holds the extended operands, stage 1 the product, later stages carry it forward.
  for (genvar s = 0; s < NUM_STAGE - 1; s++) begin : g_stage
    mul_mode_t     m_in;
    logic [PW-1:0] d_in;

    if (s == 0) begin : g_src
      assign m_in = in_mode;
      assign d_in = {a_ext, b_ext};
    end else if (s == 1) begin : g_src
      assign m_in = m_q[0];
      assign d_in = prod;
    end else begin : g_src
      assign m_in = m_q[s-1];
      assign d_in = d_q[s-1];
    end

    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
        m_q[s] <= '0;
        d_q[s] <= '0;
      end else if (advance) begin
        m_q[s] <= m_in;
        d_q[s] <= d_in;
      end
    end
  end

  if (NUM_STAGE == 1) begin : g_last_src
    assign narrow_p = PW'(a_ext) * PW'(b_ext);
    assign narrow_m = in_mode;
  end else if (NUM_STAGE == 2) begin : g_last_src
    assign narrow_p = prod;
    assign narrow_m = m_q[0];
  end else begin : g_last_src
    assign narrow_p = d_q[NUM_STAGE-2];
    assign narrow_m = m_q[NUM_STAGE-2];
  end

  rendering_mul_narrow #(
    .A_WIDTH (din0_WIDTH),
    .B_WIDTH (din1_WIDTH),
    .DW      (dout_WIDTH),
    .SAT     (SAT)
  ) u_narrow (
    .p    (narrow_p),
    .mode (narrow_m),
    .dout (narrow_dout),
    .ovf  (narrow_ovf)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (advance) begin
      dout_q <= narrow_dout;
      ovf_q  <= narrow_ovf;
    end
  end

  assign out_valid = vld_q[NUM_STAGE-1];
  assign dout      = dout_q;
  assign dout_ovf  = ovf_q;

endmodule

// File: tb/tb_rendering_mul_pipe.sv
// tb/tb_rendering_mul_pipe.sv - self-checking bench over three multiplier configurations
module tb_rendering_mul_pipe;

  localparam int STG  [3] = '{3, 1, 2};
  localparam int DWS  [3] = '{26, 16, 16};
  localparam int SATS [3] = '{0, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ap_rst_n;
  logic        ce;
  logic [2:0]  in_valid_v;
  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [2:0]  out_ready_v;
  logic [2:0]  ovf_v;
  logic [2:0]  sgn0_v;
  logic [2:0]  sgn1_v;
  logic [13:0] din0_v [3];
  logic [11:0] din1_v [3];
  logic [25:0] dout_a;
  logic [15:0] dout_b;
  logic [15:0] dout_c;
  logic [63:0] dout_v [3];

  assign dout_v[0] = {38'd0, dout_a};
  assign dout_v[1] = {48'd0, dout_b};
  assign dout_v[2] = {48'd0, dout_c};

  rendering_mul_pipe #(.ID(1), .NUM_STAGE(STG[0]), .din0_WIDTH(14), .din1_WIDTH(12),
                       .dout_WIDTH(DWS[0]), .SAT(SATS[0])) u_dut (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .ce(ce),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .din0(din0_v[0]), .din1(din1_v[0]), .sgn0(sgn0_v[0]), .sgn1(sgn1_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .dout(dout_a), .dout_ovf(ovf_v[0]));

  rendering_mul_pipe #(.ID(2), .NUM_STAGE(STG[1]), .din0_WIDTH(14), .din1_WIDTH(12),
                       .dout_WIDTH(DWS[1]), .SAT(SATS[1])) u_sat (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .ce(ce),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .din0(din0_v[1]), .din1(din1_v[1]), .sgn0(sgn0_v[1]), .sgn1(sgn1_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .dout(dout_b), .dout_ovf(ovf_v[1]));

  rendering_mul_pipe #(.ID(3), .NUM_STAGE(STG[2]), .din0_WIDTH(14), .din1_WIDTH(12),
                       .dout_WIDTH(DWS[2]), .SAT(SATS[2])) u_wrap (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .ce(ce),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .din0(din0_v[2]), .din1(din1_v[2]), .sgn0(sgn0_v[2]), .sgn1(sgn1_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .dout(dout_c), .dout_ovf(ovf_v[2]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint dmask(input int g);
    return (64'sd1 <<< DWS[g]) - 64'sd1;
  endfunction

  // Reference: exact integer product, then range test against the result range for the mode.
  function automatic logic [64:0] model(input int g, input logic [13:0] a, input logic [11:0] b,
                                        input logic sa, input logic sb);
    longint av, bv, p, lo, hi, d;
    logic   ov;
    av = longint'({50'd0, a});
    bv = longint'({52'd0, b});
    if (sa && a[13]) av = av - 64'sd16384;
    if (sb && b[11]) bv = bv - 64'sd4096;
    p = av * bv;
    d = p;
    ov = 1'b0;
    if (DWS[g] < 27) begin
      if (sa || sb) begin
        lo = -(64'sd1 <<< (DWS[g] - 1));
        hi = (64'sd1 <<< (DWS[g] - 1)) - 64'sd1;
      end else begin
        lo = 0;
        hi = dmask(g);
      end
      ov = (p < lo) || (p > hi);
      if (SATS[g] != 0 && ov) d = (p < lo) ? lo : hi;
    end
    return {ov, 64'(d & dmask(g))};
  endfunction

  // Scoreboard: one circular buffer of expected results per instance.
  logic [64:0] sb_mem [3][64];
  int          wr [3];
  int          rd [3];
  bit          held [3];
  logic [63:0] hold_d [3];
  logic        hold_o [3];

  initial begin
    for (int g = 0; g < 3; g++) begin
      wr[g] = 0; rd[g] = 0; held[g] = 0; hold_d[g] = '0; hold_o[g] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!ap_rst_n) begin
        rd[g]   = wr[g];
        held[g] = 0;
      end else begin
        if (held[g])
          check(out_valid_v[g] && dout_v[g] == hold_d[g] && ovf_v[g] == hold_o[g],
                "hold_stable", longint'(dout_v[g]), longint'(hold_d[g]));
        check(in_ready_v[g] == (ce & ~(out_valid_v[g] & ~out_ready_v[g])), "in_ready_rule",
              longint'(in_ready_v[g]), longint'(ce & ~(out_valid_v[g] & ~out_ready_v[g])));
        if (in_valid_v[g] && in_ready_v[g]) begin
          sb_mem[g][wr[g] % 64] = model(g, din0_v[g], din1_v[g], sgn0_v[g], sgn1_v[g]);
          wr[g]++;
        end
        if (out_valid_v[g] && out_ready_v[g] && ce) begin
          if (rd[g] == wr[g]) begin
            check(1'b0, "unexpected_result", longint'(dout_v[g]), 0);
          end else begin
            check({ovf_v[g], dout_v[g]} == sb_mem[g][rd[g] % 64], "result",
                  longint'({ovf_v[g], dout_v[g][62:0]}), longint'(sb_mem[g][rd[g] % 64][63:0]));
            rd[g]++;
          end
        end
        held[g]   = out_valid_v[g] && !(out_ready_v[g] && ce);
        hold_d[g] = dout_v[g];
        hold_o[g] = ovf_v[g];
      end
    end
  end

  task automatic idle_inputs();
    ce = 1'b1;
    in_valid_v  = '0;
    out_ready_v = '1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    @(posedge clk); #1;
    idle_inputs();
    while ((rd[0] != wr[0] || rd[1] != wr[1] || rd[2] != wr[2]) && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    for (int g = 0; g < 3; g++) check(rd[g] == wr[g], name, rd[g], wr[g]);
  endtask

  task automatic run_vec(input int g, input logic [13:0] a, input logic [11:0] b,
                         input logic sa, input logic sb,
                         output logic [63:0] d, output logic o, output int lat, output bit seen);
    @(posedge clk); #1;
    din0_v[g] = a; din1_v[g] = b; sgn0_v[g] = sa; sgn1_v[g] = sb;
    in_valid_v[g] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[g] = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid_v[g] && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    seen = out_valid_v[g];
    d = dout_v[g];
    o = ovf_v[g];
  endtask

  function automatic logic [13:0] pick_a();
    case ($urandom_range(0, 4))
      0: return 14'h0000;
      1: return 14'h3FFF;
      2: return 14'h2000;
      3: return 14'h1FFF;
      default: return 14'($urandom);
    endcase
  endfunction

  function automatic logic [11:0] pick_b();
    case ($urandom_range(0, 4))
      0: return 12'h000;
      1: return 12'hFFF;
      2: return 12'h800;
      3: return 12'h7FF;
      default: return 12'($urandom);
    endcase
  endfunction

  typedef struct {
    int          g;
    logic [13:0] a;
    logic [11:0] b;
    logic        sa;
    logic        sb;
    longint      exp_d;
    logic        exp_o;
  } vec_t;

  vec_t vt [10];

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] got_d;
    logic        got_o;
    int          lat;
    bit          seen;
    int          j;

    vt[0] = '{0, 14'h2000, 12'h7FF, 1'b1, 1'b1, -64'sd16769024, 1'b0};
    vt[1] = '{0, 14'h3FFF, 12'hFFF, 1'b0, 1'b0, 64'sd67088385, 1'b0};
    vt[2] = '{0, 14'h3FFF, 12'hFFF, 1'b0, 1'b1, -64'sd16383, 1'b0};
    vt[3] = '{0, 14'h2000, 12'h800, 1'b1, 1'b1, 64'sd16777216, 1'b0};
    vt[4] = '{1, 14'd300, 12'd200, 1'b1, 1'b1, 64'sd32767, 1'b1};
    vt[5] = '{1, 14'h3ED4, 12'd200, 1'b1, 1'b1, -64'sd32768, 1'b1};
    vt[6] = '{1, 14'd300, 12'd200, 1'b0, 1'b0, 64'sd60000, 1'b0};
    vt[7] = '{2, 14'd300, 12'd200, 1'b1, 1'b1, -64'sd5536, 1'b1};
    vt[8] = '{2, 14'h3ED4, 12'd200, 1'b1, 1'b1, 64'sd5536, 1'b1};
    vt[9] = '{2, 14'h3FFF, 12'hFFF, 1'b0, 1'b1, -64'sd16383, 1'b0};

    ap_rst_n = 1'b0;
    idle_inputs();
    for (int g = 0; g < 3; g++) begin
      din0_v[g] = '0; din1_v[g] = '0;
    end
    sgn0_v = '0; sgn1_v = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) check(!in_ready_v[g], "in_ready_in_reset", in_ready_v[g], 0);
    @(posedge clk); #1;
    ap_rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check(!out_valid_v[g], "reset_out_valid", out_valid_v[g], 0);
      check(dout_v[g] == 0, "reset_dout", longint'(dout_v[g]), 0);
      check(!ovf_v[g], "reset_ovf", ovf_v[g], 0);
      check(in_ready_v[g], "reset_in_ready", in_ready_v[g], 1);
    end

    for (int i = 0; i < 10; i++) begin
      run_vec(vt[i].g, vt[i].a, vt[i].b, vt[i].sa, vt[i].sb, got_d, got_o, lat, seen);
      check(seen, "vec_timeout", i, 1);
      check(lat == STG[vt[i].g] - 1, "vec_latency", lat, STG[vt[i].g] - 1);
      check(got_d == 64'(vt[i].exp_d & dmask(vt[i].g)), "vec_dout",
            longint'(got_d), vt[i].exp_d & dmask(vt[i].g));
      check(got_o == vt[i].exp_o, "vec_ovf", got_o, vt[i].exp_o);
    end
    drain("drain_vectors");

    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      ce = ($urandom_range(0, 9) != 0);
      for (int g = 0; g < 3; g++) begin
        in_valid_v[g]  = ($urandom_range(0, 3) != 0);
        out_ready_v[g] = ($urandom_range(0, 3) != 0);
        din0_v[g] = pick_a();
        din1_v[g] = pick_b();
        sgn0_v[g] = 1'($urandom);
        sgn1_v[g] = 1'($urandom);
      end
    end
    drain("drain_random");

    j = 0;
    for (int c = 0; c < 40 && (j < 8 || c < 12); c++) begin
      @(posedge clk); #1;
      out_ready_v[0] = !(c >= 4 && c < 9);
      in_valid_v[0]  = (j < 8);
      din0_v[0] = 14'(j * 1031 + 17);
      din1_v[0] = 12'(j * 263 + 5);
      sgn0_v[0] = 1'(j);
      sgn1_v[0] = 1'(j >> 1);
      @(negedge clk);
      if (in_valid_v[0] && in_ready_v[0]) j++;
      if (c >= 4 && c < 9) begin
        check(out_valid_v[0], "bp_out_valid", out_valid_v[0], 1);
        check(!in_ready_v[0], "bp_in_ready", in_ready_v[0], 0);
      end
    end
    check(j == 8, "bp_all_accepted", j, 8);
    drain("drain_backpressure");

    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      ce = !(c >= 3 && c < 6);
      in_valid_v[0] = 1'b1;
      din0_v[0] = 14'(c * 123 + 5);
      din1_v[0] = 12'(c * 37 + 1);
      sgn0_v[0] = 1'(c);
      sgn1_v[0] = 1'b1;
      if (!ce) begin
        @(negedge clk);
        check(!in_ready_v[0], "ce_in_ready", in_ready_v[0], 0);
        check(out_valid_v[0], "ce_out_valid_held", out_valid_v[0], 1);
      end
    end
    drain("drain_ce");

    @(posedge clk); #1;
    din0_v[0] = 14'd77; din1_v[0] = 12'd5; sgn0_v[0] = 1'b1; sgn1_v[0] = 1'b1;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    din0_v[0] = 14'd99;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    ap_rst_n = 1'b0;
    @(posedge clk); #1;
    ap_rst_n = 1'b1;
    @(negedge clk);
    check(dout_v[0] == 0, "rst2_dout", longint'(dout_v[0]), 0);
    check(!ovf_v[0], "rst2_ovf", ovf_v[0], 0);
    check(in_ready_v[0], "rst2_in_ready", in_ready_v[0], 1);
    for (int k = 0; k < 4; k++) begin
      check(!out_valid_v[0], "rst2_no_inflight", out_valid_v[0], 0);
      @(negedge clk);
    end
    run_vec(0, 14'd1000, 12'd3, 1'b1, 1'b1, got_d, got_o, lat, seen);
    check(seen, "rst2_timeout", 0, 1);
    check(lat == 2, "rst2_latency", lat, 2);
    check(got_d == 64'd3000, "rst2_dout_after", longint'(got_d), 3000);
    drain("drain_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
